uart_rx: RTL and testbench

Serial receiver paired with the existing BaudTick-driven transmitter. It consumes the 8N1 line format that transmitter produces: start bit, 8 data bits LSB first, at least one stop bit. It oversamples the asynchronous RxD line using an 8x baud enable, recovers each byte and presents it with a one-cycle valid strobe. It sits between the board RxD pin and the byte-level consumer (command decoder / loopback to the transmitter).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx_filter.sv | 44 ++++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and 8N1 frame constants,
// reused by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 8;
  localparam int unsigned DATA_BITS          = 8;
  localparam logic        STOP_LEVEL         = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side serial line and byte-output bundle. The master modport is
// the receiver, and the slave modport is the line driver/byte consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 RxD;
  logic [DATA_BITS-1:0] RxD_data;
  logic                 RxD_data_ready;
  logic                 RxD_frame_err;
  logic                 RxD_idle;

  modport master (
    input  RxD,
    output RxD_data,
    output RxD_data_ready,
    output RxD_frame_err,
    output RxD_idle
  );

  modport slave (
    output RxD,
    input  RxD_data,
    input  RxD_data_ready,
    input  RxD_frame_err,
    input  RxD_idle
  );

endinterface

// File: rtl/uart_rx_filter.sv
// Two-flop synchronizer for the asynchronous RxD pin followed by a 2-bit
// saturating majority filter that advances only on the oversample enable.
module uart_rx_filter (
  input  logic clk,
  input  logic rst,
  input  logic Baud8Tick,
  input  logic RxD,
  output logic rx_bit
);

  logic [1:0] sync;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;

  // Saturating up/down count toward the synchronized line level
  always_comb begin
    cnt_nxt = cnt;
    if (sync[1] && (cnt != 2'd3)) begin
      cnt_nxt = cnt + 2'd1;
    end else if (!sync[1] && (cnt != 2'd0)) begin
      cnt_nxt = cnt - 2'd1;
    end
  end

  // rx_bit only flips once the counter saturates, so it holds in between
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= 2'b11;
      cnt    <= 2'd3;
      rx_bit <= 1'b1;
    end else begin
      sync <= {sync[0], RxD};
      if (Baud8Tick) begin
        cnt <= cnt_nxt;
        if (cnt_nxt == 2'd0) begin
          rx_bit <= 1'b0;
        end else if (cnt_nxt == 2'd3) begin
          rx_bit <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop recovery, a one-cycle ready
// or frame-error strobe per frame, break suppression, and idle-line detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE    = DEFAULT_OVERSAMPLE,
  parameter int unsigned IDLE_GAP_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Baud8Tick,
  uart_rx_if.master  bus
);

  localparam int unsigned PHASE_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
  localparam int unsigned GAP_MAX = IDLE_GAP_BITS * OVERSAMPLE;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [PHASE_W-1:0] PHASE_MID = PHASE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PHASE_W-1:0] PHASE_END = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [GAP_W-1:0]   GAP_SAT   = GAP_W'(GAP_MAX);

  rx_state_e            state, state_n;
  logic [PHASE_W-1:0]   phase, phase_n;
  logic [BIT_W-1:0]     bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic [DATA_BITS-1:0] data, data_n;
  logic [GAP_W-1:0]     gap, gap_n;
  logic                 ready, ready_n;
  logic                 ferr, ferr_n;
  logic                 idle, idle_n;
  logic                 rx_bit;

  uart_rx_filter u_filter (
    .clk       (clk),
    .rst       (rst),
    .Baud8Tick (Baud8Tick),
    .RxD       (bus.RxD),
    .rx_bit    (rx_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath decisions; everything advances only on a tick
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    bitcnt_n = bitcnt;
    shift_n  = shift_reg;
    data_n   = data;
    gap_n    = gap;
    ready_n  = 1'b0;
    ferr_n   = 1'b0;

    if (Baud8Tick) begin
      if (state != IDLE) begin
        phase_n = phase + PHASE_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (!rx_bit) begin
            state_n = START;
            phase_n = '0;
          end else if (gap != GAP_SAT) begin
            gap_n = gap + GAP_W'(1);
          end
        end
        START: begin
          // Half a bit in: a line that is high again was only a glitch
          if (phase == PHASE_MID) begin
            if (!rx_bit) begin
              state_n  = DATA;
              phase_n  = '0;
              bitcnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DATA: begin
          if (phase == PHASE_END) begin
            shift_n  = {rx_bit, shift_reg[DATA_BITS-1:1]};
            bitcnt_n = bitcnt + BIT_W'(1);
            if (bitcnt == LAST_BIT) begin
              state_n = STOP;
            end
          end
        end
        STOP: begin
          if (phase == PHASE_END) begin
            if (rx_bit == STOP_LEVEL) begin
              data_n  = shift_reg;
              ready_n = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BREAK;
            end
          end
        end
        BREAK: begin
          // Hold here until the line recovers so a stuck-low line yields one error
          if (rx_bit) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (state_n != IDLE) begin
      gap_n = '0;
    end
    idle_n = (gap_n == GAP_SAT);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      bitcnt    <= '0;
      shift_reg <= '0;
      data      <= '0;
      gap       <= '0;
      ready     <= 1'b0;
      ferr      <= 1'b0;
      idle      <= 1'b0;
    end else begin
      phase     <= phase_n;
      bitcnt    <= bitcnt_n;
      shift_reg <= shift_n;
      data      <= data_n;
      gap       <= gap_n;
      ready     <= ready_n;
      ferr      <= ferr_n;
      idle      <= idle_n;
    end
  end

  assign bus.RxD_data       = data;
  assign bus.RxD_data_ready = ready;
  assign bus.RxD_frame_err  = ferr;
  assign bus.RxD_idle       = idle;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8x ticks every 4 clks, 32 clks per bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLKS_PER_TICK = 4;
  localparam int unsigned BIT_CLKS      = 32;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic Baud8Tick = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(8), .IDLE_GAP_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .Baud8Tick (Baud8Tick),
    .bus       (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int n_ready    = 0;
  int n_ferr     = 0;
  int n_both     = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] rx_log [64];

  always #5 clk = ~clk;

  initial begin : tick_gen
    forever begin
      repeat (CLKS_PER_TICK - 1) @(negedge clk);
      Baud8Tick = 1'b1;
      @(negedge clk);
      Baud8Tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.RxD_data_ready) begin
      if (n_ready < 64) rx_log[n_ready] = bus.RxD_data;
      last_rx = bus.RxD_data;
      n_ready++;
    end
    if (bus.RxD_frame_err) n_ferr++;
    if (bus.RxD_data_ready && bus.RxD_frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.RxD = b;
    clks(BIT_CLKS);
  endtask

  task automatic send_data(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_data(b);
    send_bit(1'b1);
  endtask

  initial begin : main
    int r0;
    int f0;
    int got;
    logic [7:0] b;

    bus.RxD = 1'b1;
    rst = 1'b1;
    clks(6);
    rst = 1'b0;
    clks(1);
    check("rst_data",  32'(bus.RxD_data), 32'h00);
    check("rst_ready", 32'(bus.RxD_data_ready), 32'h0);
    check("rst_ferr",  32'(bus.RxD_frame_err), 32'h0);
    check("rst_idle",  32'(bus.RxD_idle), 32'h0);
    clks(BIT_CLKS);

    // single byte 0x55
    r0 = n_ready; f0 = n_ferr;
    send_byte(8'h55);
    clks(BIT_CLKS);
    check("b55_count", 32'(n_ready - r0), 32'd1);
    check("b55_data",  32'(last_rx), 32'h55);
    check("b55_hold",  32'(bus.RxD_data), 32'h55);
    check("b55_ferr",  32'(n_ferr - f0), 32'd0);

    // back-to-back 0xA3, 0x0F
    r0 = n_ready;
    send_byte(8'hA3);
    send_byte(8'h0F);
    clks(BIT_CLKS);
    check("b2b_count", 32'(n_ready - r0), 32'd2);
    check("b2b_first", 32'(rx_log[r0[5:0]]), 32'hA3);
    r0 = r0 + 1;
    check("b2b_second", 32'(rx_log[r0[5:0]]), 32'h0F);

    // 2-tick glitch is a false start
    r0 = n_ready; f0 = n_ferr;
    bus.RxD = 1'b0;
    clks(2 * CLKS_PER_TICK);
    bus.RxD = 1'b1;
    clks(3 * BIT_CLKS);
    check("glitch_ready", 32'(n_ready - r0), 32'd0);
    check("glitch_ferr",  32'(n_ferr - f0), 32'd0);
    check("glitch_state", 32'(dut.state), 32'(IDLE));

    // 0x81 with low stop bit, then a 40-tick break
    r0 = n_ready; f0 = n_ferr;
    send_data(8'h81);
    send_bit(1'b0);
    bus.RxD = 1'b0;
    clks(40 * CLKS_PER_TICK);
    bus.RxD = 1'b1;
    clks(2 * BIT_CLKS);
    check("brk_ferr",  32'(n_ferr - f0), 32'd1);
    check("brk_ready", 32'(n_ready - r0), 32'd0);
    check("brk_data",  32'(bus.RxD_data), 32'h0F);
    send_byte(8'h3C);
    clks(BIT_CLKS);
    check("after_brk_count", 32'(n_ready - r0), 32'd1);
    check("after_brk_data",  32'(last_rx), 32'h3C);
    check("after_brk_ferr",  32'(n_ferr - f0), 32'd1);

    // reset during data bit 4 of 0xFF
    r0 = n_ready; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.RxD = 1'b1;
    clks(12);
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(1);
    check("midrst_data",  32'(bus.RxD_data), 32'h00);
    check("midrst_idle",  32'(bus.RxD_idle), 32'h0);
    check("midrst_ready", 32'(bus.RxD_data_ready), 32'h0);
    check("midrst_ferr",  32'(bus.RxD_frame_err), 32'h0);
    clks(BIT_CLKS - 16 + 4 * BIT_CLKS);
    check("midrst_nready", 32'(n_ready - r0), 32'd0);
    check("midrst_nferr",  32'(n_ferr - f0), 32'd0);

    // 0x12, then measure the idle gap from the ready tick
    send_data(8'h12);
    bus.RxD = 1'b1;
    got = 0;
    for (int i = 0; i < 3 * BIT_CLKS && got == 0; i++) begin
      @(negedge clk);
      if (bus.RxD_data_ready) got = 1;
    end
    check("b12_seen", 32'(got), 32'd1);
    check("b12_data", 32'(bus.RxD_data), 32'h12);
    clks(127 * CLKS_PER_TICK);
    check("idle_at_127", 32'(bus.RxD_idle), 32'h0);
    clks(CLKS_PER_TICK);
    check("idle_at_128", 32'(bus.RxD_idle), 32'h1);

    // next start bit drops idle once the FSM leaves IDLE
    r0 = n_ready;
    bus.RxD = 1'b0;
    clks(2);
    check("idle_before_start", 32'(bus.RxD_idle), 32'h1);
    clks(22);
    check("idle_after_start", 32'(bus.RxD_idle), 32'h0);
    clks(BIT_CLKS - 24);
    b = 8'hC5;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(1'b1);
    clks(BIT_CLKS);
    check("bc5_count", 32'(n_ready - r0), 32'd1);
    check("bc5_data",  32'(last_rx), 32'hC5);

    check("strobe_exclusive", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
